// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage byte-wide data memory with a multi-beat access sequencer
// Word accesses take four big-endian byte beats; the pipeline is stalled until DONE.
module data_mem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              R,
    input  logic              mem_en,
    input  logic              mem_rw,
    input  logic              mem_size,
    input  logic              mem_load,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        beat;
    logic [ADDR_W-1:0] addr_l;
    logic [31:0]       wdata_l;
    logic              rw_l;
    logic              size_l;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        wr_byte;
    logic              last_beat;

    logic [7:0] Mem [0:2**ADDR_W-1];

    // Any non-store runs the read path, including the mem_load=0 decode-error case.
    logic unused_load;
    assign unused_load = mem_load;

    assign cur_addr  = addr_l + ADDR_W'(beat);
    assign last_beat = size_l ? (beat == 2'd3) : 1'b1;

    always_comb begin
        wr_byte = wdata_l[7:0];
        if (size_l) begin
            case (beat)
                2'd0:    wr_byte = wdata_l[31:24];
                2'd1:    wr_byte = wdata_l[23:16];
                2'd2:    wr_byte = wdata_l[15:8];
                default: wr_byte = wdata_l[7:0];
            endcase
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                stall = mem_en;
                if (mem_en) state_next = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (R) begin
            stall = 1'b0;
            done  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            state <= IDLE;
            beat  <= 2'd0;
            rdata <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        addr_l  <= addr;
                        wdata_l <= wdata;
                        rw_l    <= mem_rw;
                        size_l  <= mem_size;
                        beat    <= 2'd0;
                    end
                end
                BUSY: begin
                    if (!rw_l) begin
                        if (!size_l) begin
                            rdata <= {24'd0, Mem[cur_addr]};
                        end else begin
                            case (beat)
                                2'd0:    rdata[31:24] <= Mem[cur_addr];
                                2'd1:    rdata[23:16] <= Mem[cur_addr];
                                2'd2:    rdata[15:8]  <= Mem[cur_addr];
                                default: rdata[7:0]   <= Mem[cur_addr];
                            endcase
                        end
                    end
                    if (!last_beat) beat <= beat + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; a beat cut short by R is simply not written.
    always_ff @(posedge clk) begin
        if (!R && state == BUSY && rw_l) Mem[cur_addr] <= wr_byte;
    end

endmodule
